// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the slave-0 memory port arbiter: FSM states, grant side and
// the size-to-step mapping used by the burst address generator.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRd     = 2'd1,
    StWr     = 2'd2,
    StWrWait = 2'd3
  } arb_state_e;

  typedef enum logic {
    GrantRd = 1'b0,
    GrantWr = 1'b1
  } grant_side_e;

  localparam int unsigned StepWidth = 3;

  localparam logic [StepWidth-1:0] StepSize0 = 3'd1;
  localparam logic [StepWidth-1:0] StepSize1 = 3'd2;
  localparam logic [StepWidth-1:0] StepSize2 = 3'd4;

  // Size code 3 is treated like size 2 (step of 4 words).
  function automatic logic [StepWidth-1:0] size_to_step(input logic [1:0] size);
    logic [StepWidth-1:0] step;
    case (size)
      2'd0:    step = StepSize0;
      2'd1:    step = StepSize1;
      default: step = StepSize2;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_addr_gen.sv
// Burst address generator shared by the read and write sides; only one burst is
// ever active, so a single set of addr/cnt/len/step registers suffices.
module burst_addr_gen
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic [1:0]            i_size,
  input  logic                  i_advance,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [StepWidth-1:0]  r_step;
  logic [ADDR_WIDTH-1:0] w_step_ext;

  assign w_step_ext = ADDR_WIDTH'(r_step);

  // Address wraps modulo 2^ADDR_WIDTH through natural overflow.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_addr <= '0;
      r_cnt  <= '0;
      r_len  <= '0;
      r_step <= '0;
    end else if (i_load) begin
      r_addr <= i_addr;
      r_cnt  <= '0;
      r_len  <= i_len;
      r_step <= size_to_step(i_size);
    end else if (i_advance) begin
      r_addr <= r_addr + w_step_ext;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_cnt == r_len);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port slave-0 memory between the master-0 read and write
// channels, alternating grants under contention and sequencing whole bursts.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  input  logic [1:0]            rd_size,
  output logic                  rd_grant,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [LEN_WIDTH-1:0]  wr_len,
  input  logic [1:0]            wr_size,
  output logic                  wr_grant,
  input  logic [DATA_WIDTH-1:0] wr_wdata,
  input  logic                  wr_wvalid,
  output logic                  wr_wready,
  output logic                  wr_done,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_wfinish
);

  arb_state_e  r_state;
  arb_state_e  w_state_next;
  grant_side_e r_last_grant;
  grant_side_e w_last_grant_next;
  logic        r_rd_valid;
  logic        r_rd_last;

  logic                  w_grant_rd;
  logic                  w_grant_wr;
  logic                  w_load;
  logic                  w_advance;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_ld_addr;
  logic [LEN_WIDTH-1:0]  w_ld_len;
  logic [1:0]            w_ld_size;

  // Grants are held off while clr is asserted so every output reads 0 in reset.
  always_comb begin
    w_grant_rd = 1'b0;
    w_grant_wr = 1'b0;
    if (r_state == StIdle && !clr) begin
      if (rd_req && (!wr_req || r_last_grant == GrantWr)) begin
        w_grant_rd = 1'b1;
      end else if (wr_req) begin
        w_grant_wr = 1'b1;
      end
    end
  end

  assign w_load    = w_grant_rd | w_grant_wr;
  assign w_ld_addr = w_grant_rd ? rd_addr : wr_addr;
  assign w_ld_len  = w_grant_rd ? rd_len  : wr_len;
  assign w_ld_size = w_grant_rd ? rd_size : wr_size;

  burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .clr       (clr),
    .i_load    (w_load),
    .i_addr    (w_ld_addr),
    .i_len     (w_ld_len),
    .i_size    (w_ld_size),
    .i_advance (w_advance),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_advance         = 1'b0;
    mem_cs            = 1'b0;
    mem_we            = 1'b0;
    mem_raddr         = '0;
    mem_waddr         = '0;
    mem_wdata         = '0;
    wr_wready         = 1'b0;
    wr_done           = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_grant_rd) begin
          w_state_next      = StRd;
          w_last_grant_next = GrantRd;
        end else if (w_grant_wr) begin
          w_state_next      = StWr;
          w_last_grant_next = GrantWr;
        end
      end
      StRd: begin
        mem_cs    = 1'b1;
        mem_raddr = w_addr;
        w_advance = 1'b1;
        if (w_last) begin
          w_state_next = StIdle;
        end
      end
      StWr: begin
        wr_wready = 1'b1;
        if (wr_wvalid) begin
          mem_we       = 1'b1;
          mem_waddr    = w_addr;
          mem_wdata    = wr_wdata;
          w_state_next = StWrWait;
        end
      end
      StWrWait: begin
        if (mem_wfinish) begin
          if (w_last) begin
            wr_done      = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_advance    = 1'b1;
            w_state_next = StWr;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Read return pipeline runs regardless of state, so a write may start while
  // the final read beat is still coming back.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= StIdle;
      r_last_grant <= GrantWr;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
      r_rd_valid   <= mem_cs;
      r_rd_last    <= mem_cs & w_last;
    end
  end

  assign rd_grant = w_grant_rd;
  assign wr_grant = w_grant_wr;
  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;
  assign rd_data  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        clr;
  logic        rd_req;
  logic [6:0]  rd_addr;
  logic [3:0]  rd_len;
  logic [1:0]  rd_size;
  logic        rd_grant;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        wr_req;
  logic [6:0]  wr_addr;
  logic [3:0]  wr_len;
  logic [1:0]  wr_size;
  logic        wr_grant;
  logic [31:0] wr_wdata;
  logic        wr_wvalid;
  logic        wr_wready;
  logic        wr_done;
  logic        mem_cs;
  logic        mem_we;
  logic [6:0]  mem_raddr;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_wfinish;

  int total = 0;
  int bad   = 0;

  // Memory stub controls
  int fast      = 1;
  int spur_en   = 0;
  int force_fin = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH (7),
    .DATA_WIDTH (32),
    .LEN_WIDTH  (4)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_len      (rd_len),
    .rd_size     (rd_size),
    .rd_grant    (rd_grant),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_last     (rd_last),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_len      (wr_len),
    .wr_size     (wr_size),
    .wr_grant    (wr_grant),
    .wr_wdata    (wr_wdata),
    .wr_wvalid   (wr_wvalid),
    .wr_wready   (wr_wready),
    .wr_done     (wr_done),
    .mem_cs      (mem_cs),
    .mem_we      (mem_we),
    .mem_raddr   (mem_raddr),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_wfinish (mem_wfinish)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] hash(input logic [6:0] a);
    return {a, 25'd0} ^ (32'h9E3779B9 * {25'd0, a});
  endfunction

  function automatic int step_of(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [6:0] beat_addr(input int base, input int step, input int idx);
    return 7'((base + idx * step) % 128);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #3 clr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 clr = 1'b0;
  endtask

  // Memory stub: read data one cycle after mem_cs, write-finish after a delay.
  int          fin_cnt = 0;
  logic        stub_rd_hit = 1'b0;
  logic [6:0]  stub_rd_a = '0;
  initial begin
    mem_rdata   = '0;
    mem_wfinish = 1'b0;
    forever begin
      @(negedge clk);
      if (clr) begin
        fin_cnt     = 0;
        stub_rd_hit = 1'b0;
      end else begin
        stub_rd_hit = mem_cs;
        stub_rd_a   = mem_raddr;
        if (mem_we) fin_cnt = (fast != 0) ? 1 : int'($urandom_range(1, 3));
      end
      @(posedge clk);
      #2;
      mem_rdata   = stub_rd_hit ? hash(stub_rd_a) : $urandom;
      mem_wfinish = 1'b0;
      if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) mem_wfinish = 1'b1;
      end else if (spur_en != 0 && $urandom_range(0, 7) == 0) begin
        mem_wfinish = 1'b1;
      end
      if (force_fin != 0) mem_wfinish = 1'b1;
    end
  end

  // Reference model: one active burst described by base/step/beat index.
  int          m_busy = 0, m_is_rd = 0, m_base = 0, m_step = 1, m_beats = 1;
  int          m_idx = 0, m_wait = 0, m_last_rd = 0, m_rv = 0, m_rl = 0;
  logic [31:0] m_rdata = '0;

  initial begin : model_check
    logic        e_grd, e_gwr, e_cs, e_we, e_wready, e_done;
    logic [6:0]  e_raddr, e_waddr;
    logic [31:0] e_wdata;
    forever begin
      @(negedge clk);
      if (clr) begin
        m_busy = 0; m_last_rd = 0; m_rv = 0; m_rl = 0; m_wait = 0;
        check("m_rst_grant", {30'd0, rd_grant, wr_grant}, 32'd0);
        check("m_rst_strobe", {29'd0, mem_cs, mem_we, wr_wready}, 32'd0);
        check("m_rst_ret", {29'd0, rd_valid, rd_last, wr_done}, 32'd0);
      end else begin
        e_grd = 1'b0; e_gwr = 1'b0; e_cs = 1'b0; e_we = 1'b0;
        e_wready = 1'b0; e_done = 1'b0; e_raddr = '0; e_waddr = '0; e_wdata = '0;
        if (m_busy == 0) begin
          if (rd_req && (!wr_req || m_last_rd == 0)) e_grd = 1'b1;
          else if (wr_req) e_gwr = 1'b1;
        end else if (m_is_rd != 0) begin
          e_cs    = 1'b1;
          e_raddr = beat_addr(m_base, m_step, m_idx);
        end else if (m_wait == 0) begin
          e_wready = 1'b1;
          if (wr_wvalid) begin
            e_we    = 1'b1;
            e_waddr = beat_addr(m_base, m_step, m_idx);
            e_wdata = wr_wdata;
          end
        end else if (mem_wfinish && m_idx == m_beats - 1) begin
          e_done = 1'b1;
        end

        check("rd_grant", {31'd0, rd_grant}, {31'd0, e_grd});
        check("wr_grant", {31'd0, wr_grant}, {31'd0, e_gwr});
        check("mem_cs", {31'd0, mem_cs}, {31'd0, e_cs});
        check("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        check("wr_wready", {31'd0, wr_wready}, {31'd0, e_wready});
        check("wr_done", {31'd0, wr_done}, {31'd0, e_done});
        check("rd_valid", {31'd0, rd_valid}, 32'(m_rv));
        check("rd_last", {31'd0, rd_last}, 32'(m_rl));
        if (e_cs) check("mem_raddr", {25'd0, mem_raddr}, {25'd0, e_raddr});
        if (e_we) begin
          check("mem_waddr", {25'd0, mem_waddr}, {25'd0, e_waddr});
          check("mem_wdata", mem_wdata, e_wdata);
        end
        if (m_rv != 0) check("rd_data", rd_data, m_rdata);

        m_rv = int'(e_cs);
        m_rl = (e_cs && m_idx == m_beats - 1) ? 1 : 0;
        if (e_cs) m_rdata = hash(e_raddr);
        if (e_grd) begin
          m_busy = 1; m_is_rd = 1; m_base = int'(rd_addr); m_step = step_of(rd_size);
          m_beats = int'(rd_len) + 1; m_idx = 0; m_wait = 0; m_last_rd = 1;
        end else if (e_gwr) begin
          m_busy = 1; m_is_rd = 0; m_base = int'(wr_addr); m_step = step_of(wr_size);
          m_beats = int'(wr_len) + 1; m_idx = 0; m_wait = 0; m_last_rd = 0;
        end else if (m_busy != 0 && m_is_rd != 0) begin
          m_idx++;
          if (m_idx == m_beats) m_busy = 0;
        end else if (m_busy != 0 && m_wait == 0) begin
          if (wr_wvalid) m_wait = 1;
        end else if (m_busy != 0 && mem_wfinish) begin
          if (m_idx == m_beats - 1) m_busy = 0;
          else begin
            m_idx++;
            m_wait = 0;
          end
        end
      end
    end
  end

  task automatic read_burst(input logic [6:0] a, input logic [3:0] l, input logic [1:0] s,
                            output logic [3:0][6:0] got, output int nv, output int lastk,
                            output int ng);
    tick();
    rd_req = 1'b1; rd_addr = a; rd_len = l; rd_size = s;
    settle();
    ng    = int'(rd_grant);
    nv    = 0;
    lastk = -1;
    got   = '0;
    for (int k = 1; k <= int'(l) + 6; k++) begin
      tick();
      rd_req = 1'b0;
      settle();
      if (k <= 4 && mem_cs) got[k-1] = mem_raddr;
      nv += int'(rd_valid);
      if (rd_last) lastk = k;
    end
  endtask

  logic [3:0][6:0] got;
  logic [3:0][6:0] exp_a;
  logic [3:0][1:0] seq;
  logic [3:0][1:0] exp_seq;
  int nv, lastk, ng, nwe, ndone, donek, rl_cnt;
  logic rd_pend_g, wr_pend_g;
  int clr_pending;

  initial begin
    clr = 1'b1;
    rd_req = 1'b1; rd_addr = 7'h11; rd_len = 4'd0; rd_size = 2'd0;
    wr_req = 1'b1; wr_addr = 7'h22; wr_len = 4'd0; wr_size = 2'd0;
    wr_wdata = '0; wr_wvalid = 1'b1;
    #12;
    check("reset_grants", {30'd0, rd_grant, wr_grant}, 32'd0);
    check("reset_strobes", {29'd0, mem_cs, mem_we, wr_wready}, 32'd0);
    check("reset_addrs", {18'd0, mem_raddr, mem_waddr}, 32'd0);
    check("reset_wdata", mem_wdata, 32'd0);
    check("reset_ret", {29'd0, rd_valid, rd_last, wr_done}, 32'd0);
    rd_req = 1'b0; wr_req = 1'b0; wr_wvalid = 1'b0;
    @(posedge clk);
    #2 clr = 1'b0;

    // Read only, step 4
    read_burst(7'h08, 4'd2, 2'd2, got, nv, lastk, ng);
    exp_a = {7'h00, 7'h10, 7'h0C, 7'h08};
    check("rd8_grant", 32'(ng), 32'd1);
    for (int i = 0; i < 3; i++) check("rd8_addr", {25'd0, got[i]}, {25'd0, exp_a[i]});
    check("rd8_nvalid", 32'(nv), 32'd3);
    check("rd8_last_cycle", 32'(lastk), 32'd4);

    // Write only, step 1, finish one cycle after each strobe
    tick();
    wr_req = 1'b1; wr_addr = 7'h02; wr_len = 4'd3; wr_size = 2'd0;
    wr_wvalid = 1'b1; wr_wdata = 32'h1000;
    settle();
    check("wr2_grant", {31'd0, wr_grant}, 32'd1);
    nwe = 0; ndone = 0; donek = -1; got = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      wr_req = 1'b0; wr_wdata = 32'h1000 + 32'(k);
      settle();
      if (mem_we) begin
        if (nwe < 4) got[nwe] = mem_waddr;
        nwe++;
      end
      if (wr_done) begin
        ndone++;
        donek = k;
      end
    end
    wr_wvalid = 1'b0;
    exp_a = {7'h05, 7'h04, 7'h03, 7'h02};
    check("wr2_nwe", 32'(nwe), 32'd4);
    for (int i = 0; i < 4; i++) check("wr2_addr", {25'd0, got[i]}, {25'd0, exp_a[i]});
    check("wr2_ndone", 32'(ndone), 32'd1);
    check("wr2_done_cycle", 32'(donek), 32'd8);

    // Alternation from reset: read first, then write, read, write
    pulse_clr();
    tick();
    rd_req = 1'b1; rd_addr = 7'h10; rd_len = 4'd1; rd_size = 2'd0;
    wr_req = 1'b1; wr_addr = 7'h30; wr_len = 4'd0; wr_size = 2'd0; wr_wvalid = 1'b1;
    ng = 0; seq = '0;
    for (int k = 0; k < 80 && ng < 4; k++) begin
      if (k > 0) tick();
      settle();
      if (k == 0) check("both_first_rd", {31'd0, rd_grant}, 32'd1);
      if (rd_grant) begin
        seq[ng] = 2'd1;
        ng++;
      end
      if (wr_grant && ng < 4) begin
        seq[ng] = 2'd2;
        ng++;
      end
    end
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (10) tick();
    wr_wvalid = 1'b0;
    exp_seq = {2'd2, 2'd1, 2'd2, 2'd1};
    check("alt_count", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++) check("alt_order", {30'd0, seq[i]}, {30'd0, exp_seq[i]});

    // Address wrap
    read_burst(7'h7E, 4'd3, 2'd1, got, nv, lastk, ng);
    exp_a = {7'h04, 7'h02, 7'h00, 7'h7E};
    check("wrap_grant", 32'(ng), 32'd1);
    for (int i = 0; i < 4; i++) check("wrap_addr", {25'd0, got[i]}, {25'd0, exp_a[i]});
    check("wrap_last_cycle", 32'(lastk), 32'd5);

    // Write stalls with wvalid low; a stray wfinish in WR must not count
    tick();
    wr_req = 1'b1; wr_addr = 7'h40; wr_len = 4'd0; wr_size = 2'd0; wr_wvalid = 1'b0;
    settle();
    check("stall_grant", {31'd0, wr_grant}, 32'd1);
    ndone = 0; nwe = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      wr_req    = 1'b0;
      force_fin = (k == 3) ? 1 : 0;
      settle();
      nwe   += int'(mem_we);
      ndone += int'(wr_done);
      check("stall_wready", {31'd0, wr_wready}, 32'd1);
    end
    check("stall_no_we", 32'(nwe), 32'd0);
    check("stall_no_done", 32'(ndone), 32'd0);
    tick();
    force_fin = 0; wr_wvalid = 1'b1; wr_wdata = 32'hDEADBEEF;
    settle();
    check("stall_we", {31'd0, mem_we}, 32'd1);
    check("stall_waddr", {25'd0, mem_waddr}, 32'h40);
    check("stall_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    wr_wvalid = 1'b0;
    settle();
    check("stall_wait_ready", {31'd0, wr_wready}, 32'd0);
    check("stall_done", {31'd0, wr_done}, 32'd1);

    // Reset during the second beat of a 4-beat read
    tick();
    rd_req = 1'b1; rd_addr = 7'h20; rd_len = 4'd3; rd_size = 2'd0;
    tick();
    rd_req = 1'b0;
    tick();
    #2 clr = 1'b1;
    #1;
    check("clr_async_cs", {31'd0, mem_cs}, 32'd0);
    check("clr_async_valid", {31'd0, rd_valid}, 32'd0);
    check("clr_async_raddr", {25'd0, mem_raddr}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 clr = 1'b0;
    rl_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      settle();
      rl_cnt += int'(rd_last);
    end
    check("clr_no_last", 32'(rl_cnt), 32'd0);
    read_burst(7'h11, 4'd0, 2'd0, got, nv, lastk, ng);
    check("clr_regrant", 32'(ng), 32'd1);
    check("clr_regrant_addr", {25'd0, got[0]}, 32'h11);
    check("clr_regrant_last", 32'(lastk), 32'd2);

    // Randomized traffic checked by the model
    fast = 0; spur_en = 1; clr_pending = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rd_pend_g = rd_grant;
      wr_pend_g = wr_grant;
      @(posedge clk);
      #1;
      if (rd_req && rd_pend_g) rd_req = 1'b0;
      if (wr_req && wr_pend_g) wr_req = 1'b0;
      if (!rd_req && $urandom_range(0, 3) == 0) begin
        rd_req = 1'b1; rd_addr = 7'($urandom); rd_len = 4'($urandom); rd_size = 2'($urandom);
      end
      if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req = 1'b1; wr_addr = 7'($urandom); wr_len = 4'($urandom); wr_size = 2'($urandom);
      end
      wr_wvalid = ($urandom_range(0, 9) < 6);
      wr_wdata  = $urandom;
      if (clr_pending != 0) begin
        #2 clr = 1'b0;
        clr_pending = 0;
      end else if ($urandom_range(0, 499) == 0) begin
        #2 clr = 1'b1;
        clr_pending = 1;
      end
    end
    if (clr_pending != 0) begin
      @(posedge clk);
      #3 clr = 1'b0;
    end
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Slave-side controller that shares the single-port slave 0 `Memory` between the master 0 read channel and the master 0 write channel. It accepts one burst request from each side, grants them in strict alternation when both are pending, and generates the memory strobes and beat addresses for the whole burst. It sits between the read/write master logic in `top` and the `Memory` instance (CS/WE/RADDR/WADDR/Mem_in/Mem_out/writefinish).

## Interface
- ADDR_WIDTH, 7, memory word-address width
- DATA_WIDTH, 32, data width
- LEN_WIDTH, 4, burst length field (beats − 1)

Ports:
- clk  in  1  single clock, rising edge
- clr  in  1  asynchronous, active-high reset
- rd_req  in  1  read burst request, held until rd_grant
- rd_addr  in  ADDR_WIDTH  start word address
- rd_len  in  LEN_WIDTH  beats − 1
- rd_size  in  2  address step: 0→1, 1→2, 2→4, 3→4
- rd_grant  out  1  one-cycle accept pulse
- rd_data  out  DATA_WIDTH  returned beat data
- rd_valid  out  1  rd_data valid
- rd_last  out  1  final beat of burst, with rd_valid
- wr_req, wr_addr, wr_len, wr_size  in  1/ADDR_WIDTH/LEN_WIDTH/2  write burst request, same rules as read
- wr_grant  out  1  one-cycle accept pulse
- wr_wdata  in  DATA_WIDTH  write beat data
- wr_wvalid  in  1  write beat present
- wr_wready  out  1  arbiter can take a beat
- wr_done  out  1  one-cycle pulse, burst fully written
- mem_cs  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_raddr, mem_waddr  out  ADDR_WIDTH  beat addresses
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_cs
- mem_wfinish  in  1  memory write-complete pulse

## Operation
- States: IDLE, RD, WR, WR_WAIT. Registers: state, addr, beat count, len, step, last_grant, rd_valid/rd_last pipeline.
- IDLE: if only one req, grant it. If both, grant the side not in last_grant (reset value WR, so read wins first). Grant is combinational in IDLE; on the same edge addr←*_addr, cnt←0, len/step latched, last_grant updated, state→RD/WR.
- RD: every cycle mem_cs=1, mem_raddr=addr; addr←addr+step (mod 2^ADDR_WIDTH), cnt++. When cnt==len, go to IDLE.
- Read return: rd_valid/rd_last registered copies of mem_cs / (mem_cs && cnt==len); rd_data=mem_rdata passthrough. Independent of state, so a following write may start while last read beat returns.
- WR: wr_wready=1. On wr_wvalid: mem_we=1, mem_waddr=addr, mem_wdata=wr_wdata, go to WR_WAIT. mem_wfinish is ignored in WR.
- WR_WAIT: wr_wready=0. On mem_wfinish: if cnt==len, wr_done=1 and go to IDLE. Otherwise addr+=step, cnt++, go to WR. No timeout.
- Bursts are never interrupted. Step 3 is treated as 4. Address wraps silently.

## Timing
- Reset (async, clr=1): state IDLE, last_grant=WR, addr/cnt 0. All outputs 0 (rd_data follows mem_rdata). Reset mid-burst abandons it and issues no done/last.
- Request sampled in IDLE at cycle T gives grant at T. First mem_cs at T+1, rd_valid T+2, rd_last T+2+len. IDLE again at T+1+len+1, where a new grant is possible.
- Write beat n: mem_we in the cycle wr_wvalid&&wr_wready. Minimum 2 cycles per beat (WR→WR_WAIT, with mem_wfinish at the earliest in the next cycle).
- mem_cs and mem_we are never both 1.
- A req asserted in the same cycle the other burst ends is served from IDLE the following cycle.

## Structure
- Shared package: state encoding (IDLE/RD/WR/WR_WAIT), size→step constants, grant-side enum (GRANT_RD/GRANT_WR).
- One sub-module, `burst_addr_gen`: holds the addr/cnt/step registers, with load, advance and last outputs. Instanced once and shared by both sides, since only one burst is active at a time.

## Test plan
- Read only: rd_addr=0x08, len=2, size=2 → grant, then mem_raddr 0x08, 0x0C, 0x10 on consecutive cycles. Three rd_valid pulses, rd_last on the 3rd.
- Write only: wr_addr=0x02, len=3, size=0, memory returns wfinish 1 cycle after each we → mem_waddr 0x02..0x05, four mem_we pulses, single wr_done after the 4th wfinish.
- Both req at once from reset → read granted first; after it ends, the write is granted. Both re-requested → read again only after the write.
- Wrap: rd_addr=0x7E, len=3, size=1 → addresses 0x7E, 0x00, 0x02, 0x04.
- wr_wvalid held low 5 cycles in WR → no mem_we, wr_wready stays 1, no state change. Spurious mem_wfinish in WR is ignored.
- clr pulsed during beat 2 of a 4-beat read → all outputs 0 asynchronously, no rd_last. The next rd_req is granted normally.
